// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receiver for 8N1-style framing (DATA_BITS data bits, LSB first,
//   one stop bit). Runs on the same oversampled clock as the matching
//   transmitter: one bit period is OVERSAMPLING clk_in cycles.
//
// Parameters
//   OVERSAMPLING : clk_in cycles per bit (even, >= 4)
//   DATA_BITS    : data bits per frame (1..8)
//
// Ports
//   clk_in           : clock, baud rate * OVERSAMPLING
//   rst_in           : synchronous active-high reset
//   rx_serial_in     : asynchronous serial line, idle high
//   rx_data_out      : last good received word, LSB = first bit on the line
//   rx_valid_out     : one-cycle pulse, rx_data_out has just been updated
//   rx_frame_err_out : one-cycle pulse, stop bit was sampled low
//   rx_busy_out      : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  output logic                 rx_frame_err_out,
  output logic                 rx_busy_out
);

  localparam int HALF = OVERSAMPLING / 2;
  localparam int CW   = $clog2(OVERSAMPLING);
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] OS_M1    = CW'(OVERSAMPLING - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // Two-flop synchronizer; both stages idle high so reset never looks
  // like a start bit.
  logic                   sync1_q;
  logic                   rx_s;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rx_serial_in;
      rx_s    <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        // Half a bit in: a still-low line is a real start bit, anything
        // else was a glitch and is dropped silently.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        // Aligned to the start-bit centre, so each full period lands on
        // the centre of the next data bit.
        if (cnt_q == OS_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        // Leaving at the stop-bit centre lets a start bit follow the stop
        // bit immediately.
        if (cnt_q == OS_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    rx_busy_out      = (state_q != IDLE);
    rx_data_out      = data_q;
    rx_valid_out     = valid_q;
    rx_frame_err_out = err_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Drives serial frames built from the
//   framing rules, predicts each output pulse (kind, word, cycle) from the
//   latency formula and compares against a monitor. A second instance
//   covers OVERSAMPLING=16 / DATA_BITS=7.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS  = 8;
  localparam int DB  = 8;
  localparam int OS2 = 16;
  localparam int DB2 = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           line_a = 1'b1;
  logic           line_b = 1'b1;

  logic [DB-1:0]  data_a;
  logic           valid_a, err_a, busy_a;
  logic [DB2-1:0] data_b;
  logic           valid_b, err_b, busy_b;

  int unsigned    cyc = 0;
  int unsigned    checks = 0;
  int unsigned    failures = 0;
  int unsigned    ka = 0;
  int unsigned    kb = 0;
  logic [7:0]     last_good = 8'h00;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int unsigned at;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_extra;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .rx_serial_in     (line_a),
    .rx_data_out      (data_a),
    .rx_valid_out     (valid_a),
    .rx_frame_err_out (err_a),
    .rx_busy_out      (busy_a)
  );

  uart_rx #(.OVERSAMPLING(OS2), .DATA_BITS(DB2)) dut_b (
    .clk_in           (clk),
    .rst_in           (rst),
    .rx_serial_in     (line_b),
    .rx_data_out      (data_b),
    .rx_valid_out     (valid_b),
    .rx_frame_err_out (err_b),
    .rx_busy_out      (busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle (edge number) after which the pulse is visible, given the first
  // edge k that samples the start bit.
  function automatic int unsigned pulse_at(int unsigned k, int os, int db);
    return k + 2 + os / 2 + (db + 1) * os;
  endfunction

  // Line level at offset t within a frame: start, data LSB first, stop,
  // then any extra low time.
  function automatic logic frame_level(int t, logic [7:0] d, logic stop, int os, int db);
    int b;
    b = t / os;
    if (b == 0)            return 1'b0;
    else if (b <= db)      return d[b-1];
    else if (b == db + 1)  return stop;
    else                   return 1'b0;
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) line_a = v;
    else            line_b = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic stop,
                            input int low_extra, input int gap, input int os,
                            input int db, input int rst_at);
    int len;
    len = os * (db + 2) + low_extra;
    if (which == 0) ka = cyc + 1;
    else            kb = cyc + 1;
    for (int t = 0; t < len; t++) begin
      set_line(which, frame_level(t, d, stop, os, db));
      if (which == 0 && t == os + os / 2) chk("busy_midframe", {31'b0, busy_a}, 1);
      if (t == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_line(which, 1'b1);
        last_good = 8'h00;
        chk("rst_data",  {24'b0, data_a}, 0);
        chk("rst_valid", {31'b0, valid_a}, 0);
        chk("rst_err",   {31'b0, err_a}, 0);
        chk("rst_busy",  {31'b0, busy_a}, 0);
        repeat (gap) tick();
        return;
      end
      tick();
    end
    if (which == 0 && low_extra > 0) chk("busy_wait_high", {31'b0, busy_a}, 1);
    set_line(which, 1'b1);
    repeat (gap) tick();
    if (which == 0 && gap >= 4) chk("busy_idle_gap", {31'b0, busy_a}, 0);
  endtask

  task automatic expect_pulse(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.at     = pulse_at(cyc + 1, OS, DB);
    sbq.push_back(e);
  endtask

  // Monitor for the default instance: every pulse must match the head of
  // the expectation queue in kind, word and cycle.
  always @(negedge clk) begin
    if (!rst && (valid_a || err_a)) begin
      chk("pulse_exclusive", {31'b0, valid_a & err_a}, 0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {30'b0, valid_a, err_a}, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_kind", {31'b0, err_a}, {31'b0, e.is_err});
        chk("pulse_time", cyc, e.at);
        chk("pulse_data", {24'b0, data_a}, {24'b0, e.data});
      end
    end
  end

  initial begin
    logic [7:0] rd;
    logic       rs;
    int         lx, gp;
    logic       seen_b, err_seen_b;
    int unsigned at_b;

    vecs[0] = '{8'hA5, 1'b1, 0,  10, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,  0,  1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,  0,  1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 0,  12, 1'b1, 1'b0, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 40, 10, 1'b0, 1'b1, 8'h3C};
    vecs[5] = '{8'h42, 1'b1, 0,  10, 1'b1, 1'b0, 8'h42};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_data",  {24'b0, data_a}, 0);
    chk("reset_valid", {31'b0, valid_a}, 0);
    chk("reset_err",   {31'b0, err_a}, 0);
    chk("reset_busy",  {31'b0, busy_a}, 0);
    chk("reset_data_b", {25'b0, data_b}, 0);
    repeat (5) tick();

    // Directed frames: loopback word, back-to-back, framing error, recovery.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_valid || vecs[i].exp_err)
        expect_pulse(vecs[i].exp_err, vecs[i].exp_data);
      send_frame(0, vecs[i].data, vecs[i].stop, vecs[i].low_extra, vecs[i].gap, OS, DB, -1);
    end
    last_good = 8'h42;

    // Glitch: two low cycles, must be back in IDLE after edge k+6.
    line_a = 1'b0;
    ka = cyc + 1;
    tick();
    tick();
    line_a = 1'b1;
    tick();
    tick();
    chk("glitch_busy_k3", {31'b0, busy_a}, 1);
    tick();
    tick();
    chk("glitch_busy_k5", {31'b0, busy_a}, 1);
    tick();
    chk("glitch_idle_k6", {31'b0, busy_a}, 0);
    repeat (5) tick();
    expect_pulse(1'b0, 8'h5A);
    send_frame(0, 8'h5A, 1'b1, 0, 10, OS, DB, -1);
    last_good = 8'h5A;

    // Reset during data bit 3 of 0xC3; no pulse may follow for it.
    send_frame(0, 8'hC3, 1'b1, 0, 20, OS, DB, 4 * OS + 3);
    chk("rst_hold_data", {24'b0, data_a}, 0);
    expect_pulse(1'b0, 8'h99);
    send_frame(0, 8'h99, 1'b1, 0, 10, OS, DB, -1);
    last_good = 8'h99;

    // Randomized frames against the framing/latency model.
    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      lx = rs ? 0 : int'($urandom_range(0, 30));
      gp = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(4, 15));
      if (!rs && gp < 4) gp = 4;
      if (rs) begin
        expect_pulse(1'b0, rd);
        last_good = rd;
      end else begin
        expect_pulse(1'b1, last_good);
      end
      send_frame(0, rd, rs, lx, gp, OS, DB, -1);
    end

    repeat (100) tick();
    chk("scoreboard_drained", sbq.size(), 0);

    // Second instance: OVERSAMPLING=16, DATA_BITS=7.
    seen_b = 1'b0;
    err_seen_b = 1'b0;
    at_b = 0;
    fork
      send_frame(1, 8'h55, 1'b1, 0, 10, OS2, DB2, -1);
      begin
        for (int i = 0; i < 400 && !seen_b; i++) begin
          @(negedge clk);
          if (err_b) err_seen_b = 1'b1;
          if (valid_b) begin
            seen_b = 1'b1;
            at_b = cyc;
          end
        end
      end
    join
    chk("sweep_seen", {31'b0, seen_b}, 1);
    chk("sweep_err", {31'b0, err_seen_b}, 0);
    chk("sweep_time", at_b, pulse_at(kb, OS2, DB2));
    chk("sweep_data", {25'b0, data_b}, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream counterpart of the team's UART transmitter.
- Consumes the serial line and recovers DATA_BITS-wide words (8N1 framing, LSB first).
- Runs on the same oversampled clock as the transmitter (one bit = OVERSAMPLING clk_in cycles), so a TX serial output can drive rx_serial_in directly for loopback.
- Presents each received word with a one-cycle valid strobe and flags framing errors.

Parameters:
- OVERSAMPLING, 8, clk_in cycles per bit; even, >= 4.
- DATA_BITS, 8, data bits per frame, 1..8.

Ports:
- clk_in  in  1  clock, baud rate * OVERSAMPLING.
- rst_in  in  1  reset; synchronous to clk_in, active-high.
- rx_serial_in  in  1  asynchronous serial line; idle high.
- rx_data_out  out  DATA_BITS  last good received word, LSB = first bit on the line.
- rx_valid_out  out  1  one-cycle pulse: rx_data_out updated.
- rx_frame_err_out  out  1  one-cycle pulse: stop bit sampled low.
- rx_busy_out  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Sync: 2-flop synchronizer on rx_serial_in, both flops reset to 1. FSM uses only the second-stage output rx_s. No other combinational path from input to outputs.
- Reset (rst_in high at a clk_in edge) has priority over everything, including mid-frame. It sets:
  - state = IDLE, cnt = 0, bit index = 0;
  - rx_data_out = 0, rx_valid_out = 0, rx_frame_err_out = 0, rx_busy_out = 0.
  - No partial word is ever emitted after reset.
- Counters: cnt is $clog2(OVERSAMPLING) bits wide; bit index is wide enough for DATA_BITS-1. HALF = OVERSAMPLING/2.
- rx_valid_out and rx_frame_err_out default to 0 every cycle and are never high simultaneously.
- State machine:
  - IDLE: if rx_s == 0, go to START with cnt = 0.
  - START: increment cnt. At cnt == HALF-1 (mid start bit):
    - rx_s == 0: go to DATA, cnt = 0, index = 0.
    - rx_s == 1: glitch, go to IDLE; no output pulse.
  - DATA: increment cnt. At cnt == OVERSAMPLING-1:
    - store rx_s into shift bit [index] and set cnt = 0;
    - if index == DATA_BITS-1, go to STOP; else index + 1.
  - STOP: increment cnt. At cnt == OVERSAMPLING-1 (mid stop bit):
    - rx_s == 1: rx_data_out <= shifted word, rx_valid_out = 1 for one cycle, go to IDLE.
    - rx_s == 0: rx_frame_err_out = 1 for one cycle, rx_data_out unchanged, go to WAIT_HIGH.
  - WAIT_HIGH (break / bad frame): stay until rx_s == 1, then go to IDLE. A line held low never triggers a new start.
- Latency: let k be the first clk_in edge that samples rx_serial_in low.
  - Start check occurs at edge k+2+HALF.
  - Data bit i is sampled at edge k+2+HALF+(i+1)*OVERSAMPLING.
  - The valid/error pulse is high in the cycle after edge k+2+HALF+(DATA_BITS+1)*OVERSAMPLING.
  - Defaults (8, 8): pulse after edge k+78.
- Returning to IDLE at the stop-bit centre allows back-to-back frames, i.e. a start bit immediately following the stop bit.
- rx_data_out holds its value until the next good frame.

Test Plan:
- Loopback: TX (OVERSAMPLING=8, DATA_BITS=8) drives rx_serial_in and sends 0xA5 -> exactly one rx_valid_out pulse, rx_data_out = 0xA5, 78 cycles after rx start edge, rx_frame_err_out never high.
- Back-to-back: TX sends 0x00, 0xFF, 0x3C with data_rdy held high -> three valid pulses with 0x00, 0xFF, 0x3C in order; no errors; rx_busy_out low only between frames.
- Glitch: drive line low for 2 cycles then high -> returns to IDLE by edge k+6, no pulses; a following frame 0x5A is received correctly.
- Framing error: bench-driven frame 0x81 with stop bit 0, line held low 40 more cycles, then high -> one rx_frame_err_out pulse; rx_data_out keeps its previous value; FSM stays in WAIT_HIGH until line high; next frame 0x42 is valid.
- Reset mid-frame: assert rst_in for 1 cycle during data bit 3 of 0xC3 -> next cycle all outputs 0 and rx_busy_out = 0; no pulse for the aborted frame; subsequent frame 0x99 is received correctly.
- Parameter sweep: OVERSAMPLING=16, DATA_BITS=7, send 0x55 -> rx_data_out = 0x55; pulse after edge k+2+8+8*16 = k+138.
